// File: rtl/key_event_counter_if.sv
// rtl/key_event_counter_if.sv - key/count signal bundle between the button front end and the BCD display
interface key_event_counter_if;
  logic       key_n;
  logic       clr;
  logic       dir;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [3:0] digit2;
  logic [3:0] digit3;
  logic       press_pulse;
  logic       wrap;
  logic       key_held;

  modport master (
    output key_n, clr, dir,
    input  digit0, digit1, digit2, digit3, press_pulse, wrap, key_held
  );

  modport slave (
    input  key_n, clr, dir,
    output digit0, digit1, digit2, digit3, press_pulse, wrap, key_held
  );
endinterface

// File: rtl/key_event_counter.sv
// rtl/key_event_counter.sv - debounced push-button driving a 4-digit BCD up/down counter
// Define KEY_AUTO_REPEAT_EN to add a repeat step every REPEAT_CYCLES while the key stays pressed.
module key_event_counter #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input logic              CLOCK_50,
  input logic              RESET_N,
  key_event_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  localparam logic [23:0] DB_LAST = 24'(DEBOUNCE_CYCLES - 1);

  state_t      state;
  state_t      next_state;
  logic        key_m;
  logic        key_s;
  logic [23:0] db_cnt;
  logic        db_done;
  logic        press_step;
  logic        rep_step;
  logic        step;
  logic        key_held;
  logic [3:0]  digits [4];
  logic [3:0]  nxt    [4];
  logic        carry;
  logic        press_pulse;
  logic        wrap;

  // Synchronizer idles high so reset looks like a released key.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_m <= 1'b1;
      key_s <= 1'b1;
    end else begin
      key_m <= bus.key_n;
      key_s <= key_m;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= next_state;
  end

  assign db_done = (db_cnt == DB_LAST);

  always_comb begin
    next_state = state;
    press_step = 1'b0;
    case (state)
      IDLE:         if (!key_s) next_state = PRESS_WAIT;
      PRESS_WAIT: begin
        if (key_s) next_state = IDLE;
        else if (db_done) begin
          next_state = PRESSED;
          press_step = 1'b1;
        end
      end
      PRESSED:      if (key_s) next_state = RELEASE_WAIT;
      RELEASE_WAIT: begin
        if (!key_s) next_state = PRESSED;
        else if (db_done) next_state = IDLE;
      end
      default:      next_state = IDLE;
    endcase
  end

  always_comb begin
    key_held = (state == PRESSED) || (state == RELEASE_WAIT);
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)                  db_cnt <= '0;
    else if (state != next_state)  db_cnt <= '0;
    else if (state == PRESS_WAIT || state == RELEASE_WAIT)
                                   db_cnt <= db_cnt + 24'd1;
    else                           db_cnt <= '0;
  end

`ifdef KEY_AUTO_REPEAT_EN
  localparam int              REP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_run;

  assign rep_run  = (state == PRESSED) && !key_s;
  assign rep_step = rep_run && (rep_cnt == REP_LAST);

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N)                                    rep_cnt <= '0;
    else if (bus.clr || !rep_run || rep_step)        rep_cnt <= '0;
    else                                             rep_cnt <= rep_cnt + 1'b1;
  end
`else
  localparam int unused_repeat_cycles = REPEAT_CYCLES;
  assign rep_step = 1'b0;
`endif

  assign step = press_step | rep_step;

  // Ripple carry/borrow digit by digit; carry surviving all four digits is the wrap.
  always_comb begin
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nxt[i] = digits[i];
      if (carry) begin
        if (!bus.dir) begin
          if (digits[i] == 4'd9) nxt[i] = 4'd0;
          else begin
            nxt[i] = digits[i] + 4'd1;
            carry  = 1'b0;
          end
        end else begin
          if (digits[i] == 4'd0) nxt[i] = 4'd9;
          else begin
            nxt[i] = digits[i] - 4'd1;
            carry  = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
      press_pulse <= 1'b0;
      wrap        <= 1'b0;
    end else if (bus.clr) begin
      for (int i = 0; i < 4; i++) digits[i] <= 4'd0;
      press_pulse <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      press_pulse <= step;
      wrap        <= step & carry;
      if (step) begin
        for (int i = 0; i < 4; i++) digits[i] <= nxt[i];
      end
    end
  end

  assign bus.digit0      = digits[0];
  assign bus.digit1      = digits[1];
  assign bus.digit2      = digits[2];
  assign bus.digit3      = digits[3];
  assign bus.press_pulse = press_pulse;
  assign bus.wrap        = wrap;
  assign bus.key_held    = key_held;

endmodule

// File: tb/tb_key_event_counter.sv
// tb/tb_key_event_counter.sv - self-checking bench for key_event_counter (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10)
module tb_key_event_counter;
  localparam int D = 4;
  localparam int R = 10;
`ifdef KEY_AUTO_REPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  key_event_counter_if bus();

  key_event_counter #(.DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(R)) dut (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus)
  );

  typedef struct {
    bit do_clr;
    int pre_ups;
    bit d;
    int exp_val;
    int exp_wrap;
  } vec_t;

  vec_t tbl [9];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   npulse = 0;
  int   nwrap = 0;
  bit   bad_digit = 1'b0;
  bit   held_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.press_pulse) npulse++;
    if (bus.wrap) nwrap++;
    if (bus.key_held) held_seen = 1'b1;
    if (bus.digit0 > 4'd9 || bus.digit1 > 4'd9 || bus.digit2 > 4'd9 || bus.digit3 > 4'd9)
      bad_digit = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int dval();
    return int'(bus.digit3) * 1000 + int'(bus.digit2) * 100 + int'(bus.digit1) * 10 + int'(bus.digit0);
  endfunction

  task automatic check(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic press(input bit d, input int hold);
    bus.dir   = d;
    bus.key_n = 1'b0;
    tick(hold);
    bus.key_n = 1'b1;
    tick(D + 6);
  endtask

  task automatic clr_pulse();
    bus.clr = 1'b1;
    tick(1);
    bus.clr = 1'b0;
    tick(1);
  endtask

  initial begin
    int p0, w0, val, es, ew, len;
    bit acc_low, lvl, dr;

    tbl[0] = '{1'b1, 0,  1'b1, 9999, 1};
    tbl[1] = '{1'b0, 0,  1'b0, 0,    1};
    tbl[2] = '{1'b0, 0,  1'b0, 1,    0};
    tbl[3] = '{1'b0, 0,  1'b1, 0,    0};
    tbl[4] = '{1'b0, 0,  1'b1, 9999, 1};
    tbl[5] = '{1'b0, 0,  1'b1, 9998, 0};
    tbl[6] = '{1'b1, 99, 1'b0, 100,  0};
    tbl[7] = '{1'b0, 0,  1'b1, 99,   0};
    tbl[8] = '{1'b1, 9,  1'b0, 10,   0};

    bus.key_n = 1'b1;
    bus.clr   = 1'b0;
    bus.dir   = 1'b0;
    tick(3);
    check("reset_digits", dval(), 0);
    check("reset_pulse", int'(bus.press_pulse), 0);
    check("reset_wrap", int'(bus.wrap), 0);
    check("reset_held", int'(bus.key_held), 0);
    rst_n = 1'b1;
    tick(4);

    // Clean 20-cycle press: step lands on edge 7 after the fall
    p0 = npulse;
    bus.dir   = 1'b0;
    bus.key_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 6) check("lat_pulse_e6", int'(bus.press_pulse), 0);
      if (i == 7) begin
        check("lat_pulse_e7", int'(bus.press_pulse), 1);
        check("lat_digits_e7", dval(), 1);
        check("lat_held_e7", int'(bus.key_held), 1);
      end
    end
    bus.key_n = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      tick(1);
      if (j == 6) check("rel_held_e6", int'(bus.key_held), 1);
      if (j == 7) check("rel_held_e7", int'(bus.key_held), 0);
    end
    tick(2);
    check("clean_pulses", npulse - p0, 1 + AR);
    check("clean_digits", dval(), 1 + AR);

    for (int k = 0; k < 9; k++) begin
      if (tbl[k].do_clr) clr_pulse();
      for (int u = 0; u < tbl[k].pre_ups; u++) press(1'b0, 8);
      p0 = npulse;
      w0 = nwrap;
      press(tbl[k].d, 8);
      check($sformatf("tbl%0d_digits", k), dval(), tbl[k].exp_val);
      check($sformatf("tbl%0d_wrap", k), nwrap - w0, tbl[k].exp_wrap);
      check($sformatf("tbl%0d_pulses", k), npulse - p0, 1);
    end

    // Bounce rejection from 0005
    clr_pulse();
    for (int u = 0; u < 5; u++) press(1'b0, 8);
    p0 = npulse;
    held_seen = 1'b0;
    bus.key_n = 1'b0; tick(2);
    bus.key_n = 1'b1; tick(2);
    bus.key_n = 1'b0; tick(2);
    bus.key_n = 1'b1; tick(D + 6);
    check("bounce_pulses", npulse - p0, 0);
    check("bounce_held", int'(held_seen), 0);
    check("bounce_digits", dval(), 5);

    // clr on the step edge wins over the step
    p0 = npulse;
    w0 = nwrap;
    bus.dir   = 1'b0;
    bus.key_n = 1'b0;
    tick(6);
    bus.clr = 1'b1;
    tick(1);
    check("clrstep_pulse", int'(bus.press_pulse), 0);
    check("clrstep_wrap", int'(bus.wrap), 0);
    check("clrstep_digits", dval(), 0);
    check("clrstep_held", int'(bus.key_held), 1);
    bus.clr = 1'b0;
    tick(1);
    bus.key_n = 1'b1;
    tick(D + 6);
    check("clrstep_total", npulse - p0, 0);

    // Reset mid PRESS_WAIT, then a held key is a fresh press
    press(1'b0, 8);
    press(1'b0, 8);
    bus.key_n = 1'b0;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("rstpw_digits", dval(), 0);
    check("rstpw_held", int'(bus.key_held), 0);
    check("rstpw_pulse", int'(bus.press_pulse), 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    check("rstpw_pulse_e6", int'(bus.press_pulse), 0);
    tick(1);
    check("rstpw_pulse_e7", int'(bus.press_pulse), 1);
    check("rstpw_digits_e7", dval(), 1);
    tick(2);
    check("rsthold_held", int'(bus.key_held), 1);
    rst_n = 1'b0;
    #1;
    check("rsthold_held_rst", int'(bus.key_held), 0);
    check("rsthold_digits", dval(), 0);
    tick(2);
    rst_n = 1'b1;
    p0 = npulse;
    tick(7);
    check("rsthold_pulse_e7", int'(bus.press_pulse), 1);
    check("rsthold_digits_e7", dval(), 1);
    bus.key_n = 1'b1;
    tick(D + 6);
    check("rsthold_total", npulse - p0, 1);

    // 40-cycle hold: auto-repeat adds three steps when built in
    clr_pulse();
    p0 = npulse;
    bus.dir   = 1'b0;
    bus.key_n = 1'b0;
    tick(40);
    bus.key_n = 1'b1;
    tick(D + 8);
    check("hold40_pulses", npulse - p0, 1 + 3 * AR);
    check("hold40_digits", dval(), 1 + 3 * AR);

    // Random runs against a run-length model: a level is accepted after D+1 samples
    clr_pulse();
    tick(2);
    val = 0; es = 0; ew = 0; acc_low = 1'b0; dr = 1'b0;
    p0 = npulse;
    w0 = nwrap;
    for (int r = 0; r < 200; r++) begin
      lvl = (r % 2 == 1);
      if (!lvl) begin
        len = int'($urandom_range(1, 8));
        dr  = 1'($urandom_range(0, 1));
        bus.dir = dr;
      end else begin
        len = int'($urandom_range(2, 8));
      end
      bus.key_n = lvl;
      tick(len);
      if (len >= D + 1) begin
        if (!lvl && !acc_low) begin
          acc_low = 1'b1;
          es++;
          if (!dr) begin
            if (val == 9999) ew++;
            val = (val + 1) % 10000;
          end else begin
            if (val == 0) ew++;
            val = (val + 9999) % 10000;
          end
        end else if (lvl && acc_low) begin
          acc_low = 1'b0;
        end
      end
    end
    bus.key_n = 1'b1;
    tick(D + 8);
    check("rand_pulses", npulse - p0, es);
    check("rand_wraps", nwrap - w0, ew);
    check("rand_digits", dval(), val);
    check("rand_held", int'(bus.key_held), 0);
    check("digits_in_range", int'(bad_digit), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
